// File: rtl/imem_loader.sv
// Byte-stream program loader: writes framed 32-bit words into the instruction memory
// and holds the CPU in reset-like stall until a frame with a good checksum completes.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LEN0 = 3'd1;
    localparam logic [2:0] LEN1 = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] CSUM = 3'd4;
    localparam logic [2:0] DONE = 3'd5;
    localparam logic [2:0] ERR  = 3'd6;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    logic [2:0]        state_q,   state_d;
    logic [7:0]        lenLo_q,   lenLo_d;
    logic [ADDR_W:0]   remain_q,  remain_d;
    logic [1:0]        byteIdx_q, byteIdx_d;
    logic [7:0]        csum_q,    csum_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [23:0]       asm_q,     asm_d;
    logic              memWe_q,   memWe_d;
    logic [ADDR_W-1:0] waddr_q,   waddr_d;
    logic [31:0]       wdata_q,   wdata_d;

    logic        accept;
    logic [15:0] lenWord;

    assign in_ready_o  = (state_q == LEN0) || (state_q == LEN1) ||
                         (state_q == DATA) || (state_q == CSUM);
    assign busy_o      = in_ready_o;
    // ERR keeps the CPU held so a half-loaded image can never run.
    assign cpu_hold_o  = in_ready_o || (state_q == ERR);
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == ERR);
    assign mem_we_o    = memWe_q;
    assign mem_waddr_o = waddr_q;
    assign mem_wdata_o = wdata_q;

    assign accept  = in_valid_i && in_ready_o;
    assign lenWord = {in_data_i, lenLo_q};

    always_comb begin
        state_d   = state_q;
        lenLo_d   = lenLo_q;
        remain_d  = remain_q;
        byteIdx_d = byteIdx_q;
        csum_d    = csum_q;
        addr_d    = addr_q;
        asm_d     = asm_q;
        memWe_d   = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (load_start_i) begin
                    state_d   = LEN0;
                    addr_d    = '0;
                    csum_d    = '0;
                    byteIdx_d = '0;
                end
            end
            LEN0: begin
                if (accept) begin
                    lenLo_d = in_data_i;
                    state_d = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    if (lenWord == 16'd0 || {1'b0, lenWord} > MAX_WORDS) begin
                        state_d = ERR;
                    end else begin
                        remain_d = lenWord[ADDR_W:0];
                        state_d  = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d    = csum_q ^ in_data_i;
                    byteIdx_d = byteIdx_q + 2'd1;
                    case (byteIdx_q)
                        2'd0: asm_d[7:0]   = in_data_i;
                        2'd1: asm_d[15:8]  = in_data_i;
                        2'd2: asm_d[23:16] = in_data_i;
                        default: begin
                            memWe_d  = 1'b1;
                            waddr_d  = addr_q;
                            wdata_d  = {in_data_i, asm_q};
                            remain_d = remain_q - (ADDR_W+1)'(1);
                            // The address stops on the last word so it never wraps past the top.
                            if (remain_q == (ADDR_W+1)'(1)) begin
                                state_d = CSUM;
                            end else begin
                                addr_d = addr_q + ADDR_W'(1);
                            end
                        end
                    endcase
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d = (in_data_i == csum_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            lenLo_q   <= '0;
            remain_q  <= '0;
            byteIdx_q <= '0;
            csum_q    <= '0;
            addr_q    <= '0;
            asm_q     <= '0;
            memWe_q   <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            lenLo_q   <= lenLo_d;
            remain_q  <= remain_d;
            byteIdx_q <= byteIdx_d;
            csum_q    <= csum_d;
            addr_q    <= addr_d;
            asm_q     <= asm_d;
            memWe_q   <= memWe_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as frames are sent
// and matched against every mem_we seen on the falling edge.
module tb_imem_loader;

    localparam int ADDR_W = 10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk;
    logic              reset;
    logic              loadStart;
    logic              inValid;
    logic [7:0]        inData;
    logic              inReady;
    logic              memWe;
    logic [ADDR_W-1:0] memWaddr;
    logic [31:0]       memWdata;
    logic              cpuHold;
    logic              busy;
    logic              done;
    logic              err;

    int checks   = 0;
    int failures = 0;
    int writesSeen = 0;
    wr_t expQ[$];
    logic [31:0] wordMem [0:1023];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .load_start_i (loadStart),
        .in_valid_i   (inValid),
        .in_data_i    (inData),
        .in_ready_o   (inReady),
        .mem_we_o     (memWe),
        .mem_waddr_o  (memWaddr),
        .mem_wdata_o  (memWdata),
        .cpu_hold_o   (cpuHold),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        if (memWe === 1'b1) begin
            writesSeen++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_we", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("we_addr", 32'(memWaddr), 32'(e.addr));
                checkOutput("we_data", memWdata, e.data);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the byte is taken.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int tmo;
        inValid = 1'b0;
        repeat (gap) @(negedge clk);
        inData  = b;
        inValid = 1'b1;
        tmo = 0;
        while (!inReady && tmo < 200) begin
            @(negedge clk);
            tmo++;
        end
        if (!inReady) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            inValid = 1'b0;
        end else begin
            @(negedge clk);
            inValid = 1'b0;
        end
    endtask

    task automatic startLoad();
        loadStart = 1'b1;
        @(negedge clk);
        loadStart = 1'b0;
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_hold", 32'(cpuHold), 32'd1);
        checkOutput("start_ready", 32'(inReady), 32'd1);
        checkOutput("start_done", 32'(done), 32'd0);
        checkOutput("start_err", 32'(err), 32'd0);
    endtask

    task automatic sendFrame(input int n, input int gapMax, input logic [7:0] csumFlip, input int pulseAt);
        logic [7:0] cs;
        logic [15:0] nw;
        logic [31:0] w;
        nw = 16'(n);
        cs = 8'h00;
        applyStimulus(nw[7:0], $urandom_range(0, gapMax));
        applyStimulus(nw[15:8], $urandom_range(0, gapMax));
        for (int i = 0; i < n; i++) begin
            if (i == pulseAt) begin
                loadStart = 1'b1;
                @(negedge clk);
                loadStart = 1'b0;
            end
            w = wordMem[i];
            for (int k = 0; k < 4; k++) begin
                logic [7:0] b;
                b = w[8*k +: 8];
                cs = cs ^ b;
                if (k == 3) expQ.push_back('{addr: ADDR_W'(i), data: w});
                applyStimulus(b, $urandom_range(0, gapMax));
            end
        end
        applyStimulus(cs ^ csumFlip, $urandom_range(0, gapMax));
    endtask

    task automatic checkEnd(input string tag, input logic expDone);
        checkOutput({tag, "_done"}, 32'(done), 32'(expDone));
        checkOutput({tag, "_err"}, 32'(err), 32'(!expDone));
        checkOutput({tag, "_hold"}, 32'(cpuHold), 32'(!expDone));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_ready"}, 32'(inReady), 32'd0);
        checkOutput({tag, "_pending"}, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int base;
        reset     = 1'b1;
        loadStart = 1'b0;
        inValid   = 1'b0;
        inData    = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_hold", 32'(cpuHold), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_ready", 32'(inReady), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_we", 32'(memWe), 32'd0);

        wordMem[0] = 32'h00A00513;
        startLoad();
        sendFrame(1, 0, 8'h00, -1);
        checkEnd("single", 1'b1);

        wordMem[0] = 32'h11111111;
        wordMem[1] = 32'h22222222;
        wordMem[2] = 32'h33333333;
        base = writesSeen;
        startLoad();
        sendFrame(3, 3, 8'h00, -1);
        checkEnd("gaps", 1'b1);
        checkOutput("gaps_count", 32'(writesSeen - base), 32'd3);

        startLoad();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        checkEnd("len0", 1'b0);

        startLoad();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h04, 0);
        checkEnd("len1025", 1'b0);

        wordMem[0] = 32'h00A00513;
        startLoad();
        sendFrame(1, 0, 8'h09, -1);
        checkEnd("badcsum", 1'b0);
        startLoad();
        sendFrame(1, 1, 8'h00, -1);
        checkEnd("recover", 1'b1);

        startLoad();
        applyStimulus(8'h02, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_we", 32'(memWe), 32'd0);
        checkOutput("rst_hold", 32'(cpuHold), 32'd0);
        checkOutput("rst_ready", 32'(inReady), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        repeat (5) @(negedge clk);
        wordMem[0] = 32'hCAFEF00D;
        wordMem[1] = 32'h0BADBEEF;
        startLoad();
        sendFrame(2, 0, 8'h00, -1);
        checkEnd("after_rst", 1'b1);

        for (int i = 0; i < 1024; i++) wordMem[i] = 32'h1000_0000 + 32'(i);
        base = writesSeen;
        startLoad();
        sendFrame(1024, 0, 8'h00, 500);
        checkEnd("max", 1'b1);
        checkOutput("max_count", 32'(writesSeen - base), 32'd1024);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
